// File: rtl/vreg_operand_fetch_pkg.sv
// Shared types and sizing for the vector register-file read path.
package vreg_operand_fetch_pkg;
    localparam int READ_PORTS = 4;
    localparam int BANK_IDX   = 2;
    localparam int NUM_BANKS  = 2 ** BANK_IDX;
    localparam int VIDX_W     = 8;
    localparam int MIDX_W     = 4;
    localparam int VLMAX      = 32;
    localparam int VREG_W     = VLMAX * 16;
    localparam int TAG_W      = 4;

    typedef logic [VIDX_W-1:0]   vsel_t;
    typedef logic [MIDX_W-1:0]   mask_sel_t;
    typedef logic [VREG_W-1:0]   vreg_t;
    typedef logic [BANK_IDX-1:0] bank_t;
    typedef logic [TAG_W-1:0]    tag_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DRAIN} fetch_state_t;

    typedef struct packed {
        vsel_t [READ_PORTS-1:0] vs;
        mask_sel_t              vms;
        logic                   mren;
        tag_t                   tag;
    } fetch_req_t;
endpackage

// File: rtl/vreg_operand_fetch_if.sv
// Request, register-file and operand-bundle signals of the operand fetch unit.
interface vreg_operand_fetch_if;
    import vreg_operand_fetch_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    vsel_t [READ_PORTS-1:0] req_vs;
    logic [READ_PORTS-1:0]  req_ren;
    mask_sel_t              req_vms;
    logic                   req_mren;
    tag_t                   req_tag;

    vsel_t [READ_PORTS-1:0] rf_vs;
    logic [READ_PORTS-1:0]  rf_ren;
    mask_sel_t              rf_vms;
    logic                   rf_mren;
    vreg_t [READ_PORTS-1:0] rf_rdata;
    logic [READ_PORTS-1:0]  rf_rvalid;
    logic [VLMAX-1:0]       rf_mdata;
    logic                   rf_mvalid;

    logic                   out_valid;
    logic                   out_ready;
    vreg_t [READ_PORTS-1:0] out_vreg;
    logic [VLMAX-1:0]       out_mask;
    tag_t                   out_tag;

    // master = the fetch unit, slave = decode / register file / execute side
    modport master (
        input  req_valid, req_vs, req_ren, req_vms, req_mren, req_tag,
        output req_ready,
        output rf_vs, rf_ren, rf_vms, rf_mren,
        input  rf_rdata, rf_rvalid, rf_mdata, rf_mvalid,
        output out_valid, out_vreg, out_mask, out_tag,
        input  out_ready
    );
    modport slave (
        output req_valid, req_vs, req_ren, req_vms, req_mren, req_tag,
        input  req_ready,
        input  rf_vs, rf_ren, rf_vms, rf_mren,
        output rf_rdata, rf_rvalid, rf_mdata, rf_mvalid,
        input  out_valid, out_vreg, out_mask, out_tag,
        output out_ready
    );
endinterface

// File: rtl/vreg_operand_fetch_pick.sv
// Bank-conflict picker: lowest-index pending slot wins each bank for this cycle.
module vreg_operand_fetch_pick
    import vreg_operand_fetch_pkg::*;
(
    input  logic [READ_PORTS-1:0]  pend_i,
    input  bank_t [READ_PORTS-1:0] bank_i,
    output logic [READ_PORTS-1:0]  issue_o
);
    logic [NUM_BANKS-1:0] taken;

    always_comb begin
        taken   = '0;
        issue_o = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (pend_i[i] && !taken[bank_i[i]]) begin
                issue_o[i]         = 1'b1;
                taken[bank_i[i]]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vreg_operand_fetch.sv
// Operand fetch: issues bank-serialized vreg reads plus one mask read and
// returns the collected operand bundle over a valid/ready handshake.
module vreg_operand_fetch
    import vreg_operand_fetch_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                flush,
    output logic                err,
    vreg_operand_fetch_if.master bus
);
    fetch_state_t           state_q, state_d;
    fetch_req_t             req_q;
    logic [READ_PORTS-1:0]  pend_q, pend_d, outst_q, outst_d;
    logic [READ_PORTS-1:0]  pick, issue, cap;
    logic                   mout_q, mout_d, first_q, first_d, miss, mcap;
    vreg_t [READ_PORTS-1:0] buf_q, buf_d;
    logic [VLMAX-1:0]       mask_q, mask_d;
    logic [1:0]             drain_q, drain_d;
    logic                   err_q, accept, spur, any_out;
    bank_t [READ_PORTS-1:0] bank;

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_bank
        assign bank[i] = req_q.vs[i][BANK_IDX-1:0];
    end

    vreg_operand_fetch_pick u_pick (.pend_i(pend_q), .bank_i(bank), .issue_o(pick));

    assign accept  = (state_q == IDLE) && bus.req_valid && !flush;
    assign issue   = (state_q == ISSUE) ? pick : '0;
    assign miss    = (state_q == ISSUE) && first_q && req_q.mren;
    assign cap     = bus.rf_rvalid & outst_q;
    assign mcap    = bus.rf_mvalid && mout_q;
    // reads leaving this cycle still owe a response, so they count as in flight
    assign any_out = (|outst_q) || mout_q || (|issue) || miss;
    assign spur    = (state_q != DRAIN) &&
                     ((|(bus.rf_rvalid & ~outst_q)) || (bus.rf_mvalid && !mout_q));

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q & ~issue;
        outst_d = (outst_q | issue) & ~cap;
        mout_d  = (mout_q || miss) && !mcap;
        first_d = first_q && (state_q != ISSUE);
        buf_d   = buf_q;
        mask_d  = mask_q;
        drain_d = drain_q;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (cap[i]) buf_d[i] = bus.rf_rdata[i];
        end
        if (mcap) mask_d = bus.rf_mdata;
        case (state_q)
            IDLE: if (accept) begin
                pend_d  = bus.req_ren;
                first_d = 1'b1;
                buf_d   = '0;
                mask_d  = bus.req_mren ? '0 : '1;
                state_d = ((|bus.req_ren) || bus.req_mren) ? ISSUE : OUT;
            end
            ISSUE: if (pend_d == '0) state_d = WAIT;
            WAIT:  if (outst_d == '0 && !mout_d) state_d = OUT;
            OUT:   if (bus.out_ready) state_d = IDLE;
            DRAIN: if (drain_q == '0) state_d = IDLE;
                   else drain_d = drain_q - 2'd1;
            default: state_d = IDLE;
        endcase
        if (flush && state_q != DRAIN) begin
            pend_d  = '0;
            outst_d = '0;
            mout_d  = 1'b0;
            buf_d   = '0;
            mask_d  = '0;
            drain_d = 2'(RD_LAT - 1);
            state_d = any_out ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            outst_q <= '0;
            mout_q  <= 1'b0;
            first_q <= 1'b0;
            buf_q   <= '0;
            mask_q  <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) req_q <= '{vs: bus.req_vs, vms: bus.req_vms,
                                   mren: bus.req_mren, tag: bus.req_tag};
            pend_q  <= pend_d;
            outst_q <= outst_d;
            mout_q  <= mout_d;
            first_q <= first_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            drain_q <= drain_d;
            err_q   <= err_q | spur;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rf_vs     = req_q.vs;
    assign bus.rf_ren    = issue;
    assign bus.rf_vms    = req_q.vms;
    assign bus.rf_mren   = miss;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_vreg  = buf_q;
    assign bus.out_mask  = mask_q;
    assign bus.out_tag   = req_q.tag;
    assign err           = err_q;
endmodule

// File: tb/tb_vreg_operand_fetch.sv
// Bench for vreg_operand_fetch: directed scenarios plus random requests against
// a bank-count latency model and a register-file content model.
module tb_vreg_operand_fetch;
    import vreg_operand_fetch_pkg::*;

    localparam int RD_LAT = 1;

    logic CLK = 1'b0, nRST = 1'b0, flush = 1'b0, err;
    vreg_operand_fetch_if bus();

    vreg_operand_fetch #(.RD_LAT(RD_LAT)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .err(err), .bus(bus.master)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    vreg_t mem [256];
    logic [VLMAX-1:0] mmem [16];
    logic [READ_PORTS-1:0] hist [$];

    // register-file model: data for index v appears one cycle after REN
    logic [READ_PORTS-1:0]  rv, inj_rv;
    vreg_t [READ_PORTS-1:0] rd;
    logic                   mv;
    logic [VLMAX-1:0]       md;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rv <= '0; mv <= 1'b0; rd <= '0; md <= '0;
        end else begin
            rv <= bus.rf_ren;
            mv <= bus.rf_mren;
            for (int i = 0; i < READ_PORTS; i++) rd[i] <= mem[bus.rf_vs[i]];
            md <= mmem[bus.rf_vms];
        end
    end
    assign bus.rf_rvalid = rv | inj_rv;
    assign bus.rf_rdata  = rd;
    assign bus.rf_mvalid = mv;
    assign bus.rf_mdata  = md;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [READ_PORTS*VREG_W-1:0] obs,
                        input logic [READ_PORTS*VREG_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed(low64)=%h expected(low64)=%h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    // one request start to finish; entered and left at posedge+1
    task automatic do_req(input vsel_t [READ_PORTS-1:0] vs, input logic [READ_PORTS-1:0] ren,
                          input mask_sel_t vms, input logic mren, input tag_t tag,
                          input int bp, input string nm);
        int cnt [NUM_BANKS];
        int k, exp_cyc, cyc, mcnt;
        logic bad;
        logic [READ_PORTS-1:0] seen;
        vreg_t [READ_PORTS-1:0] ev;
        logic [VLMAX-1:0] em;
        for (int b = 0; b < NUM_BANKS; b++) cnt[b] = 0;
        k = 0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (ren[i]) cnt[int'(vs[i]) % NUM_BANKS]++;
            ev[i] = ren[i] ? mem[vs[i]] : '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) if (cnt[b] > k) k = cnt[b];
        if (mren && k == 0) k = 1;
        exp_cyc = (k == 0) ? 1 : k + RD_LAT + 1;
        em = mren ? mmem[vms] : '1;

        bus.req_vs = vs; bus.req_ren = ren; bus.req_vms = vms;
        bus.req_mren = mren; bus.req_tag = tag; bus.req_valid = 1'b1;
        bus.out_ready = (bp == 0);
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        cyc = 1; seen = '0; bad = 1'b0; mcnt = 0; hist.delete();
        forever begin
            @(negedge CLK);
            if (bus.out_valid || cyc > 60) break;
            hist.push_back(bus.rf_ren);
            if ((seen & bus.rf_ren) != '0) bad = 1'b1;
            seen |= bus.rf_ren;
            for (int i = 0; i < READ_PORTS; i++)
                for (int j = i + 1; j < READ_PORTS; j++)
                    if (bus.rf_ren[i] && bus.rf_ren[j] && (vs[i] % NUM_BANKS) == (vs[j] % NUM_BANKS))
                        bad = 1'b1;
            if (bus.rf_mren) begin
                mcnt++;
                if (cyc != 1) bad = 1'b1;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'(exp_cyc));
        chk({nm, " issued_slots"}, 64'(seen), 64'(ren));
        chk({nm, " issue_rules"}, 64'(bad), 64'(0));
        chk({nm, " mask_reads"}, 64'(mcnt), 64'(mren));
        chkw({nm, " out_vreg"}, bus.out_vreg, ev);
        chk({nm, " out_mask"}, 64'(bus.out_mask), 64'(em));
        chk({nm, " out_tag"}, 64'(bus.out_tag), 64'(tag));
        for (int c = 0; c < bp; c++) begin
            @(posedge CLK); #1;
            if (c == bp - 1) bus.out_ready = 1'b1;
            @(negedge CLK);
            chk({nm, " bp out_valid"}, 64'(bus.out_valid), 64'(1));
            chk({nm, " bp req_ready"}, 64'(bus.req_ready), 64'(0));
            chkw({nm, " bp out_vreg"}, bus.out_vreg, ev);
            chk({nm, " bp out_mask"}, 64'(bus.out_mask), 64'(em));
        end
        @(posedge CLK); #1;
        chk({nm, " idle out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({nm, " idle req_ready"}, 64'(bus.req_ready), 64'(1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vsel_t [READ_PORTS-1:0] vs;
        for (int v = 0; v < 256; v++)
            for (int w = 0; w < VREG_W / 32; w++) mem[v][w*32 +: 32] = $urandom();
        for (int m = 0; m < 16; m++) mmem[m] = $urandom();
        inj_rv = '0;
        bus.req_valid = 1'b0; bus.req_vs = '0; bus.req_ren = '0; bus.req_vms = '0;
        bus.req_mren = 1'b0; bus.req_tag = '0; bus.out_ready = 1'b1;

        // reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst req_ready", 64'(bus.req_ready), 64'(1));
        chk("rst out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst rf_ren", 64'(bus.rf_ren), 64'(0));
        chk("rst rf_mren", 64'(bus.rf_mren), 64'(0));
        chk("rst err", 64'(err), 64'(0));
        chk("rst out_mask", 64'(bus.out_mask), 64'(0));
        chkw("rst out_vreg", bus.out_vreg, '0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        do_req({8'h0B, 8'h0A, 8'h09, 8'h08}, 4'b1111, 4'h1, 1'b1, 4'h3, 0, "nocfl");
        chk("nocfl ren c1", 64'(hist[0]), 64'(4'b1111));

        do_req({8'h0C, 8'h08, 8'h04, 8'h00}, 4'b1111, 4'h2, 1'b0, 4'h6, 0, "fullcfl");
        chk("fullcfl ren c1", 64'(hist[0]), 64'(4'b0001));
        chk("fullcfl ren c2", 64'(hist[1]), 64'(4'b0010));
        chk("fullcfl ren c3", 64'(hist[2]), 64'(4'b0100));
        chk("fullcfl ren c4", 64'(hist[3]), 64'(4'b1000));

        do_req({8'h77, 8'h33, 8'h02, 8'h01}, 4'b0011, 4'h5, 1'b0, 4'h9, 0, "partial");
        do_req({8'h10, 8'h20, 8'h30, 8'h40}, 4'b0000, 4'h0, 1'b0, 4'hA, 0, "empty");
        do_req({8'h0B, 8'h0A, 8'h09, 8'h08}, 4'b1111, 4'h7, 1'b1, 4'h4, 5, "backpr");

        // flush while the full-conflict request is mid-issue
        bus.req_vs = {8'h0C, 8'h08, 8'h04, 8'h00}; bus.req_ren = 4'b1111;
        bus.req_mren = 1'b1; bus.req_tag = 4'h2; bus.req_valid = 1'b1;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        @(negedge CLK);
        chk("flush ren c1", 64'(bus.rf_ren), 64'(4'b0001));
        @(posedge CLK); #1;
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        @(negedge CLK);
        chk("drain req_ready", 64'(bus.req_ready), 64'(0));
        chk("drain out_valid", 64'(bus.out_valid), 64'(0));
        chk("drain rf_ren", 64'(bus.rf_ren), 64'(0));
        @(posedge CLK); #1;
        chk("postdrain req_ready", 64'(bus.req_ready), 64'(1));
        chk("postdrain err", 64'(err), 64'(0));

        // flush coinciding with a request in IDLE: request dropped
        bus.req_ren = '0; bus.req_mren = 1'b0; bus.req_valid = 1'b1; flush = 1'b1;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0; flush = 1'b0;
        chk("flushreq out_valid", 64'(bus.out_valid), 64'(0));
        chk("flushreq req_ready", 64'(bus.req_ready), 64'(1));
        @(posedge CLK); #1;
        chk("flushreq out_valid2", 64'(bus.out_valid), 64'(0));

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < READ_PORTS; i++) vs[i] = vsel_t'($urandom_range(0, 255));
            do_req(vs, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), "rand");
        end
        chk("rand err", 64'(err), 64'(0));

        // spurious read data in IDLE sets a sticky error
        inj_rv = 4'b0100;
        @(posedge CLK); #1;
        inj_rv = '0;
        chk("spur err", 64'(err), 64'(1));
        repeat (3) @(posedge CLK);
        #1;
        chk("spur err held", 64'(err), 64'(1));

        // reset in the middle of a request
        bus.req_vs = {8'h0C, 8'h08, 8'h04, 8'h00}; bus.req_ren = 4'b1111;
        bus.req_mren = 1'b1; bus.req_valid = 1'b1;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        chk("midrst err", 64'(err), 64'(0));
        chk("midrst req_ready", 64'(bus.req_ready), 64'(1));
        chk("midrst out_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst rf_ren", 64'(bus.rf_ren), 64'(0));
        chk("midrst out_tag", 64'(bus.out_tag), 64'(0));
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        chk("postrst err", 64'(err), 64'(0));
        do_req({8'h05, 8'h01, 8'h0E, 8'h03}, 4'b1011, 4'h3, 1'b1, 4'hF, 1, "postrst");
        chk("final err", 64'(err), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
